// File: rtl/fsbm_pkg.sv
// Shared definitions for the full-search block-matching controller.
//   state_t  : controller FSM states
//   SAD_W_DEF, MV_W_DEF : default SAD and motion-vector widths
//   SAD_MAX  : all-ones SAD at the default width, the "no match yet" value
//   num_cand : number of candidate offsets in a +/-r window, (2r+1)^2
package fsbm_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int SAD_W_DEF = 12;
  localparam int MV_W_DEF  = 4;

  localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

  function automatic int num_cand(input int r);
    return (2 * r + 1) * (2 * r + 1);
  endfunction

endpackage

// File: rtl/fsbm_tag_pipe.sv
// PE_LAT-deep delay line for {valid, dx, dy}. Its output lines up with the
// SAD the PE returns for the same candidate.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties the pipe)
//   in_vld/dx/dy      tag entering this cycle (valid = PE enable)
//   out_vld/dx/dy     tag qualifying the current pe_sum
//   fill_nxt          some valid tag will still be in flight next cycle
//                     (the output stage itself is consumed this cycle)
module fsbm_tag_pipe #(
  parameter int PE_LAT = 1,
  parameter int MV_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  input  logic [MV_W-1:0] in_dx,
  input  logic [MV_W-1:0] in_dy,
  output logic            out_vld,
  output logic [MV_W-1:0] out_dx,
  output logic [MV_W-1:0] out_dy,
  output logic            fill_nxt
);

  logic [PE_LAT-1:0]           vld_pipe;
  logic [PE_LAT-1:0][MV_W-1:0] dx_pipe, dy_pipe;

  // Input stage prepended so element i of *_ext is the value stage i will
  // load; element PE_LAT is the pipe output.
  logic [PE_LAT:0]             vld_ext;
  logic [PE_LAT:0][MV_W-1:0]   dx_ext, dy_ext;

  assign vld_ext = {vld_pipe, in_vld};
  assign dx_ext  = {dx_pipe, in_dx};
  assign dy_ext  = {dy_pipe, in_dy};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dx_pipe  <= '0;
      dy_pipe  <= '0;
    end else begin
      vld_pipe <= vld_ext[PE_LAT-1:0];
      dx_pipe  <= dx_ext[PE_LAT-1:0];
      dy_pipe  <= dy_ext[PE_LAT-1:0];
    end
  end

  assign out_vld  = vld_ext[PE_LAT];
  assign out_dx   = dx_ext[PE_LAT];
  assign out_dy   = dy_ext[PE_LAT];
  assign fill_nxt = |vld_ext[PE_LAT-1:0];

endmodule

// File: rtl/fsbm_search_ctrl.sv
// Full-search block-matching sequencer for a 4x4 SAD PE.
// Walks every offset (dx,dy) in a +/-SEARCH_RANGE window in raster order,
// one candidate per win_ready cycle, and tracks the minimum returned SAD.
// Optional build macro: FSBM_EARLY_EXIT_EN -- a returned SAD of zero ends
// the search early (no later candidate can beat it).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                begin a search (ignored while busy)
//   win_ready            window pixels for cand_dx/dy are at the PE
//   pe_enable            PE enable for this cycle's candidate
//   cand_dx, cand_dy     signed candidate offset being issued
//   pe_sum               SAD from the PE, PE_LAT cycles after enable
//   busy, done           search in progress / one-cycle completion pulse
//   best_sad/dx/dy       running then final minimum and its motion vector
module fsbm_search_ctrl
  import fsbm_pkg::*;
#(
  parameter int SEARCH_RANGE = 4,
  parameter int PE_LAT       = 1,
  parameter int SAD_W        = SAD_W_DEF,
  parameter int MV_W         = MV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             win_ready,
  output logic             pe_enable,
  output logic [MV_W-1:0]  cand_dx,
  output logic [MV_W-1:0]  cand_dy,
  input  logic [SAD_W-1:0] pe_sum,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_dx,
  output logic [MV_W-1:0]  best_dy
);

  localparam int NUM_CAND = num_cand(SEARCH_RANGE);
  localparam int CNT_W    = $clog2(NUM_CAND);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CAND - 1);
  localparam logic [MV_W-1:0]  R_POS    = MV_W'(SEARCH_RANGE);
  localparam logic [MV_W-1:0]  R_NEG    = MV_W'(-SEARCH_RANGE);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] iss_cnt;
  logic             tag_vld, fill_nxt;
  logic [MV_W-1:0]  tag_dx, tag_dy;
  logic             stop_hit, iss_end;

`ifdef FSBM_EARLY_EXIT_EN
  // A zero SAD cannot be beaten under the strict-less rule, so stop issuing
  // in the very cycle it comes back.
  assign stop_hit = (state == ISSUE) && tag_vld && (pe_sum == '0);
`else
  assign stop_hit = 1'b0;
`endif

  fsbm_tag_pipe #(.PE_LAT(PE_LAT), .MV_W(MV_W)) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (pe_enable),
    .in_dx    (cand_dx),
    .in_dy    (cand_dy),
    .out_vld  (tag_vld),
    .out_dx   (tag_dx),
    .out_dy   (tag_dy),
    .fill_nxt (fill_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pe_enable = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    iss_end   = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        busy      = 1'b1;
        pe_enable = win_ready && !stop_hit;
        iss_end   = stop_hit || (pe_enable && (iss_cnt == LAST_CNT));
        // Skip DRAIN when nothing is left in flight beyond the result
        // being compared this cycle; keeps done PE_LAT+1 after last issue.
        if (iss_end) state_nxt = fill_nxt ? DRAIN : DONE;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!fill_nxt) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster counters and min-tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_dx  <= '0;
      cand_dy  <= '0;
      iss_cnt  <= '0;
      best_sad <= '0;
      best_dx  <= '0;
      best_dy  <= '0;
    end else if (state == IDLE && start) begin
      cand_dx  <= R_NEG;
      cand_dy  <= R_NEG;
      iss_cnt  <= '0;
      best_sad <= '1;
      best_dx  <= '0;
      best_dy  <= '0;
    end else begin
      if (iss_end) begin
        cand_dx <= '0;
        cand_dy <= '0;
      end else if (pe_enable) begin
        iss_cnt <= iss_cnt + 1'b1;
        if (cand_dx == R_POS) begin
          cand_dx <= R_NEG;
          cand_dy <= cand_dy + 1'b1;
        end else begin
          cand_dx <= cand_dx + 1'b1;
        end
      end
      // Strict less-than: on a tie the earlier raster candidate stays.
      if (tag_vld && (pe_sum < best_sad)) begin
        best_sad <= pe_sum;
        best_dx  <= tag_dx;
        best_dy  <= tag_dy;
      end
    end
  end

endmodule
